// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Power-up / re-reset controller between the clock CCC and the Murax SoC.
// It waits for a PLL lock that stays high for LOCK_CYCLES cycles, then holds
// both resets for HOLD_CYCLES cycles. It releases the peripheral reset first and
// the core reset STAGGER_CYCLES cycles later. It re-sequences on lock loss, on a
// software request and, as a build option, on a watchdog timeout. It also keeps
// a record of what caused the last sequence.
//
// Build option:
//   RESET_SEQ_WATCHDOG_EN - when defined, builds a 32-bit watchdog that counts
//                           only in RUN. When it is not defined, wdt_kick is
//                           ignored and rst_cause never reads 3.
//
// Ports:
//   clk          in   main clock (CCC GL0)
//   reset        in   synchronous active-high reset, forces WAIT_LOCK
//   pll_lock     in   CCC lock, already synchronised to clk
//   sw_rst_req   in   single-cycle software reset request (honoured in RUN)
//   wdt_kick     in   single-cycle watchdog kick
//   periph_reset out  active-high reset to peripherals
//   core_reset   out  active-high reset to the core
//   ready        out  high only in RUN
//   rst_cause    out  0 power-on, 1 lock loss, 2 software, 3 watchdog
//   state_o      out  current state encoding (debug / LED)
// All outputs are registers loaded from next-state values.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int unsigned      LOCK_CYCLES    = 1024,
    parameter int unsigned      HOLD_CYCLES    = 256,
    parameter int unsigned      STAGGER_CYCLES = 16,
    parameter longint unsigned  WDT_CYCLES     = 64'd50000000,
    parameter int unsigned      CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       sw_rst_req,
    input  logic       wdt_kick,
    output logic       periph_reset,
    output logic       core_reset,
    output logic       ready,
    output logic [1:0] rst_cause,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_PERIPH    = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    // Terminal counts: the counter is compared against N-1 so that N cycles are
    // spent in the state, and N = 1 means exactly one cycle.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      WDT_LAST  = 32'(WDT_CYCLES - 64'd1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic             ready_q, ready_d;
    logic             wdt_timeout_s;

`ifdef RESET_SEQ_WATCHDOG_EN
    logic [31:0] wdt_q, wdt_d;

    // Watchdog terminal condition: a kick in the terminal cycle prevents the timeout.
    always_comb begin
        wdt_timeout_s = (state_q == ST_RUN) && !wdt_kick && (wdt_q == WDT_LAST);
    end

    // The watchdog counts only while RUN is held and clears on a kick or on any other state.
    always_comb begin
        wdt_d = 32'd0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            if (wdt_kick) begin
                wdt_d = 32'd0;
            end else begin
                wdt_d = wdt_q + 32'd1;
            end
        end else begin
            wdt_d = 32'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdt_q <= 32'd0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    logic [1:0] unused_wdt_s;

    // Without the watchdog, the kick input and the timeout constant go unused.
    always_comb begin
        unused_wdt_s  = {wdt_kick, WDT_LAST[0]};
        wdt_timeout_s = 1'b0;
    end
`endif

    // State, counter, cause and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_WAIT_LOCK;
            cnt_q    <= CNT_ZERO;
            cause_q  <= CAUSE_POR;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state logic. The event priority is lock loss, then software request,
    // then watchdog.
    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        cause_d = cause_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (pll_lock) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                // The core is still in reset here, so a lock drop does not count as a new cause.
                if (!pll_lock) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!pll_lock) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_PERIPH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PERIPH: begin
                if (!pll_lock) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (cnt_q == STAG_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!pll_lock) begin
                    state_d = ST_WAIT_LOCK;
                    cause_d = CAUSE_LOCK;
                end else if (sw_rst_req) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_SW;
                end else if (wdt_timeout_s) begin
                    state_d = ST_HOLD;
                    cause_d = CAUSE_WDT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase
    end

    // Output decode from next state, so the outputs change on the same edge as the state.
    always_comb begin
        periph_d = 1'b1;
        core_d   = 1'b1;
        ready_d  = 1'b0;
        case (state_d)
            ST_PERIPH: begin
                periph_d = 1'b0;
            end
            ST_RUN: begin
                periph_d = 1'b0;
                core_d   = 1'b0;
                ready_d  = 1'b1;
            end
            default: begin
                periph_d = 1'b1;
                core_d   = 1'b1;
                ready_d  = 1'b0;
            end
        endcase
    end

    assign periph_reset = periph_q;
    assign core_reset   = core_q;
    assign ready        = ready_q;
    assign rst_cause    = cause_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Scoreboard bench for reset_sequencer (LOCK=4, HOLD=3, STAGGER=2, WDT=8).
// The stimulus process pushes each expected output change, with the cycle on
// which it must appear, into a queue. The monitor watches the packed output
// vector on falling edges. Whenever the vector changes, it pops the oldest
// expectation and compares both the value and the cycle. Any change that was
// not predicted is a failure. Any expectation still left in the queue at the
// end is also a failure.
// Watchdog scenarios are built only when RESET_SEQ_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_STABLE = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_PERIPH = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    logic       clk = 1'b0;
    logic       reset, pll_lock, sw_rst_req, wdt_kick;
    logic       periph_reset, core_reset, ready;
    logic [1:0] rst_cause;
    logic [2:0] state_o;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    logic       done = 1'b0;
    logic [7:0] cur_s;
    logic [7:0] prev_v = 8'hxx;

    reset_sequencer #(
        .LOCK_CYCLES    (4),
        .HOLD_CYCLES    (3),
        .STAGGER_CYCLES (2),
        .WDT_CYCLES     (64'd8),
        .CNT_W          (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .sw_rst_req   (sw_rst_req),
        .wdt_kick     (wdt_kick),
        .periph_reset (periph_reset),
        .core_reset   (core_reset),
        .ready        (ready),
        .rst_cause    (rst_cause),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign cur_s = {state_o, periph_reset, core_reset, ready, rst_cause};

    // Expected output vector for a state and cause, from the state decode table.
    function automatic logic [7:0] vec(input logic [2:0] st, input logic [1:0] cause);
        logic p, c, r;
        p = (st == S_WAIT) || (st == S_STABLE) || (st == S_HOLD);
        c = (st != S_RUN);
        r = (st == S_RUN);
        return {st, p, c, r, cause};
    endfunction

    task automatic expect_at(input int off, input logic [2:0] st, input logic [1:0] cause);
        exp_t e;
        e.cyc = cyc + off;
        e.val = vec(st, cause);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_full_seq(input logic [1:0] cause);
        expect_at(1,  S_STABLE, cause);
        expect_at(5,  S_HOLD,   cause);
        expect_at(8,  S_PERIPH, cause);
        expect_at(10, S_RUN,    cause);
    endtask

    // Monitor: compare every output change against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (cur_s !== prev_v) begin
            checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur_s);
            end else begin
                e = sb_q.pop_front();
                if ((cur_s === e.val) && (cyc == e.cyc)) begin
                    passes++;
                end else begin
                    $display("FAIL seq_step got=%h@cyc%0d required=%h@cyc%0d",
                             cur_s, cyc, e.val, e.cyc);
                end
            end
            prev_v = cur_s;
        end
        if (done) begin
            checks++;
            if (sb_q.size() == 0) begin
                passes++;
            end else begin
                $display("FAIL missing_changes got=%0d pending required=0", sb_q.size());
            end
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout got=no end required=end");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; pll_lock = 1'b0; sw_rst_req = 1'b0; wdt_kick = 1'b0;
        expect_at(1, S_WAIT, 2'd0);
        idle(3);

        // Power-on: release reset with lock high. Lock drops in the last STABLE cycle.
        reset = 1'b0; pll_lock = 1'b1;
        expect_at(1, S_STABLE, 2'd0);
        expect_at(5, S_WAIT,   2'd0);
        idle(4);
        pll_lock = 1'b0;
        idle(1);
        pll_lock = 1'b1;
        expect_full_seq(2'd0);
        idle(12);

        // Software reset in RUN, then the same pulse while in PERIPH is ignored.
        sw_rst_req = 1'b1;
        expect_at(1, S_HOLD,   2'd2);
        expect_at(4, S_PERIPH, 2'd2);
        expect_at(6, S_RUN,    2'd2);
        idle(1); sw_rst_req = 1'b0;
        idle(3); sw_rst_req = 1'b1;
        idle(1); sw_rst_req = 1'b0;
        idle(3);

        // Lock loss and software request together in RUN: lock loss wins.
        sw_rst_req = 1'b1; pll_lock = 1'b0;
        expect_at(1, S_WAIT, 2'd1);
        idle(1); sw_rst_req = 1'b0;
        idle(1); pll_lock = 1'b1;
        expect_full_seq(2'd1);
        idle(12);

        // Lock loss during HOLD after a software reset.
        sw_rst_req = 1'b1;
        expect_at(1, S_HOLD, 2'd2);
        idle(1); sw_rst_req = 1'b0; pll_lock = 1'b0;
        expect_at(1, S_WAIT, 2'd1);
        idle(1); pll_lock = 1'b1;
        expect_full_seq(2'd1);
        idle(12);

        // Reset asserted during PERIPH returns to WAIT_LOCK with power-on cause.
        sw_rst_req = 1'b1;
        expect_at(1, S_HOLD,   2'd2);
        expect_at(4, S_PERIPH, 2'd2);
        expect_at(5, S_WAIT,   2'd0);
        idle(1); sw_rst_req = 1'b0;
        idle(3); reset = 1'b1;
        idle(1); reset = 1'b0;
        expect_full_seq(2'd0);
        idle(12);

`ifdef RESET_SEQ_WATCHDOG_EN
        // Kicks every 7 cycles keep RUN.
        repeat (4) begin
            wdt_kick = 1'b1; idle(1); wdt_kick = 1'b0; idle(6);
        end
        // Kicks every 8 cycles land in the terminal cycle, so no timeout occurs.
        repeat (2) begin
            wdt_kick = 1'b1; idle(1); wdt_kick = 1'b0; idle(7);
        end
        // Withhold the kick: timeout 8 cycles after the last sampled kick.
        expect_at(1, S_HOLD,   2'd3);
        expect_at(4, S_PERIPH, 2'd3);
        expect_at(6, S_RUN,    2'd3);
        idle(8);
`else
        // Without the watchdog, RUN persists with no kicks at all.
        idle(20);
`endif
        idle(2);
        done = 1'b1;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Power-up and re-reset controller that sits between the clock CCC / system reset and the Murax SoC.
- Waits for a stable PLL lock, then holds the SoC in reset for a fixed time.
- Releases peripheral reset first and core reset a fixed number of cycles later.
- Re-sequences on lock loss, on a software reset request and, optionally, on a watchdog timeout; records the cause of the last reset.

Parameters:
- LOCK_CYCLES, 1024: consecutive cycles pll_lock must stay high before reset hold begins (1..2^CNT_W).
- HOLD_CYCLES, 256: cycles both resets are held after lock is qualified (1..2^CNT_W).
- STAGGER_CYCLES, 16: cycles between periph_reset release and core_reset release (1..2^CNT_W).
- WDT_CYCLES, 50000000: watchdog timeout in RUN, optional feature only (1..2^32).
- CNT_W, 16: width of the shared sequence counter.

Ports:
- clk  in  1  main clock (CCC GL0)
- reset  in  1  synchronous, active-high; forces WAIT_LOCK
- pll_lock  in  1  CCC LOCK, already synchronized to clk
- sw_rst_req  in  1  single-cycle software reset request from SoC GPIO
- wdt_kick  in  1  single-cycle watchdog kick
- periph_reset  out  1  active-high reset to peripherals / Blinker
- core_reset  out  1  active-high reset to the Murax core
- ready  out  1  high only in RUN
- rst_cause  out  2  cause of last sequence: 0 power-on, 1 lock loss, 2 software, 3 watchdog
- state_o  out  3  current state encoding, for debug/LED

Behaviour:
- Reset values while reset=1 (next edge):
  - state=WAIT_LOCK, cnt=0
  - periph_reset=1, core_reset=1, ready=0
  - rst_cause=0, state_o=0
- All outputs are registered and loaded from next-state, so they change on the same edge as the state register. No combinational output paths.
- State encodings: WAIT_LOCK=0, STABLE=1, HOLD=2, PERIPH=3, RUN=4.
- Output decode by state:
  - WAIT_LOCK/STABLE/HOLD: periph_reset=1, core_reset=1
  - PERIPH: periph_reset=0, core_reset=1
  - RUN: both 0, ready=1
- WAIT_LOCK: if pll_lock=1 -> STABLE, cnt=0.
- STABLE:
  - pll_lock=0 -> WAIT_LOCK.
  - Otherwise cnt++; when cnt==LOCK_CYCLES-1 -> HOLD, cnt=0.
  - Net effect: exactly LOCK_CYCLES cycles are spent in STABLE.
- HOLD: cnt++; when cnt==HOLD_CYCLES-1 -> PERIPH, cnt=0.
- PERIPH: cnt++; when cnt==STAGGER_CYCLES-1 -> RUN, cnt=0.
- RUN: stays until a re-sequence event.
- Lock loss: pll_lock=0 in HOLD, PERIPH or RUN -> WAIT_LOCK next edge, both resets asserted on that edge, rst_cause=1.
  - Lock loss in STABLE returns to WAIT_LOCK but does not change rst_cause, because the core is already in reset.
- sw_rst_req=1 in RUN with pll_lock=1 -> HOLD, cnt=0, rst_cause=2. sw_rst_req is ignored in all other states.
- Simultaneous events priority: reset > lock loss > sw_rst_req > watchdog.
- rst_cause changes only on entry into a re-sequence; it holds its value through the sequence and in RUN.
- Counter never wraps: it is cleared on every state change and compared for equality against the parameter value minus 1.
- Parameter value 1 means exactly one cycle in that state.

Optional Feature:
- Macro: RESET_SEQ_WATCHDOG_EN.
- Defined:
  - A 32-bit wdt counter runs only in RUN and is cleared in every other state and on wdt_kick=1.
  - When it reaches WDT_CYCLES-1 with no kick that cycle -> HOLD, cnt=0, rst_cause=3.
  - A kick in the terminal cycle wins, so no timeout occurs.
- Not defined:
  - No wdt counter is built; wdt_kick is ignored.
  - rst_cause never takes value 3.
  - Ports remain present.

Test Plan:
- Power-on: LOCK=4, HOLD=3, STAGGER=2. Reset, then pll_lock=1 sampled at cycle 0 -> state_o=1 at cycle 1; HOLD at cycle 5; periph_reset falls at cycle 8; core_reset falls and ready rises at cycle 10; rst_cause=0.
- Lock glitch: pll_lock drops for 1 cycle at STABLE cycle 3 -> WAIT_LOCK next edge; the full LOCK_CYCLES count restarts after lock returns; rst_cause stays 0.
- Lock loss in RUN: pll_lock=0 -> next edge core_reset=1, periph_reset=1, ready=0, rst_cause=1, state_o=0; full sequence on relock.
- Software reset: sw_rst_req pulse in RUN -> HOLD next edge, rst_cause=2, core_reset=1; RUN reached HOLD+STAGGER=5 cycles later. The same pulse in PERIPH is ignored.
- Priority: sw_rst_req=1 and pll_lock=0 in the same RUN cycle -> WAIT_LOCK, rst_cause=1. Reset asserted in PERIPH -> WAIT_LOCK, rst_cause=0.
- Watchdog (macro defined, WDT=8): kick every 7 cycles -> stays in RUN. Kick withheld -> HOLD 8 cycles after the last kick, rst_cause=3. Kick on the terminal cycle -> no timeout.
